alert_rr_scheduler: RTL and testbench
=====================================

Name: alert_rr_scheduler

Overview:
- Collects per-channel high/low alert pulses from NUM_CH sig-run-length monitors.
- Latches each alert as pending and serialises pending alerts onto one reporting port with a valid/ready handshake.
- Channels are served round-robin.
- Sits between the monitor array and the interrupt/telemetry sink; also applies a per-channel enable mask.

Parameters:
NUM_CH, 4, number of monitored channels (2..16)
ID_W, 2, width of out_ch; must equal clog2(NUM_CH)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge)
ch_high  input  NUM_CH  high_alert pulse per channel (bit i = channel i)
ch_low  input  NUM_CH  low_alert pulse per channel
enable_mask  input  NUM_CH  1 = channel alerts accepted, 0 = ignored
out_valid  output  1  alert presented on out_ch/out_type
out_ready  input  1  sink accepts alert when out_valid&out_ready
out_ch  output  ID_W  channel index of presented alert
out_type  output  1  1 = high alert, 0 = low alert
pending_any  output  1  registered OR of all pending bits
ovf  output  NUM_CH  sticky per-channel overflow flags (optional feature)
ovf_clr  input  1  clears all ovf bits (optional feature)

Behaviour:
- Reset (reset==0 at an edge): all pending bits 0, out_valid=0, out_ch=0, out_type=0, pending_any=0, rr pointer=0, state=IDLE, ovf=0.
- Reset mid-handshake abandons the presented alert; out_valid is 0 after that edge.
- Capture:
  - high_pend[i] sets at the edge where ch_high[i]&enable_mask[i]=1. low_pend[i] likewise from ch_low[i].
  - If a set and a handshake clear hit the same bit in the same cycle, set wins and the bit stays 1.
  - The mask gates setting only. Bits already pending stay pending when the mask drops.
- Request: req[i] = high_pend[i] | low_pend[i].
- Winner: the first requesting channel at or after the rr pointer, searching upward with wrap from NUM_CH-1 to 0. Within a channel, high takes priority over low.
- FSM, 2 states:
  - IDLE:
    - If any req, register out_ch=winner, out_type=(high_pend[winner]?1:0), out_valid=1, go to PRESENT.
    - Else stay in IDLE with out_valid=0.
  - PRESENT:
    - out_valid=1; out_ch/out_type held stable.
    - On out_valid&out_ready: clear the matching pending bit, rr pointer=out_ch+1 (wrapping NUM_CH-1 to 0), out_valid=0, go to IDLE.
    - Without ready, hold indefinitely. Pending bits keep capturing meanwhile.
- Latency: alert pulse at edge t sets pending; out_valid rises at edge t+1 if IDLE; sink may accept in the same cycle.
- Throughput: at most one alert per 2 cycles (one IDLE bubble).
- A channel with both bits pending gives two grants, high then low. The rr pointer advances past the channel after each grant, so other channels interleave.
- pending_any is registered from the next-state pending bits; it is 0 only when every pending bit is 0.

Optional Feature:
ALERT_OVERFLOW_EN
- Defined:
  - ovf[i] sets (sticky) when an accepted ch_high[i] or ch_low[i] pulse finds its pending bit already 1 and that bit is not being cleared by a handshake this cycle.
  - ovf_clr=1 clears all bits. Set wins over clear in the same cycle.
- Undefined: ovf is constant 0, ovf_clr is ignored, ports remain present.

Decomposition:
- Package alert_sched_pkg:
  - state enum {IDLE, PRESENT}
  - constants ALERT_LOW=1'b0, ALERT_HIGH=1'b1
  - default NUM_CH=4
- Sub-module rr_pick:
  - Pure combinational round-robin finder with inputs req[NUM_CH] and ptr[ID_W]; outputs grant_idx[ID_W] and grant_vld.
  - Instantiated once; verified standalone.

Test Plan:
- Reset low 2 cycles, then ch_high=4'b0100 for 1 cycle with mask=4'hF, out_ready=1 -> out_valid on next edge, out_ch=2, out_type=1; pending_any back to 0 after handshake.
- All four ch_low pulses in the same cycle, out_ready=1 -> grants out_ch 0,1,2,3 in order, one every 2 cycles, all out_type=0.
- ch_high[1] and ch_low[1] together plus ch_high[3], pointer=0 -> grants (1,high), (3,high), (1,low).
- out_ready=0 for 10 cycles while other alerts arrive -> out_valid/out_ch/out_type held constant; queued alerts served afterwards.
- mask=4'b1110 with ch_high[0] pulse -> nothing issued, pending_any stays 0.
- With ALERT_OVERFLOW_EN and out_ready=0: two ch_high[2] pulses -> ovf=4'b0100 until ovf_clr. Separately, drive reset=0 while out_valid=1 -> out_valid=0 on the next edge and all pending bits cleared.

Source files
------------

// File: rtl/alert_sched_pkg.sv
// Shared types and constants for the alert round-robin scheduler.
package alert_sched_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } sched_state_t;

    localparam logic ALERT_LOW  = 1'b0;
    localparam logic ALERT_HIGH = 1'b1;

    localparam int DEFAULT_NUM_CH = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first requesting index at or above ptr,
// wrapping from NUM_CH-1 back to 0.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [ID_W-1:0]   grant_idx,
    output logic              grant_vld
);

    int unsigned      sum;
    logic [ID_W-1:0]  idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            idx = ID_W'(sum);
            if (req[idx]) begin
                grant_idx = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alert_rr_scheduler.sv
// Latches per-channel high/low alerts and serialises them round-robin onto one
// valid/ready port. Optional sticky overflow flags under ALERT_OVERFLOW_EN.
module alert_rr_scheduler
    import alert_sched_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int ID_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_high,
    input  logic [NUM_CH-1:0] ch_low,
    input  logic [NUM_CH-1:0] enable_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_ch,
    output logic              out_type,
    output logic              pending_any,
    output logic [NUM_CH-1:0] ovf,
    input  logic              ovf_clr
);

    // Handshake: an alert transfers on the edge where out_valid & out_ready;
    // out_ch/out_type are stable for as long as out_valid is held.

    sched_state_t      state, state_nxt;
    logic [NUM_CH-1:0] high_pend, low_pend, high_nxt, low_nxt;
    logic [NUM_CH-1:0] set_high, set_low, clr_high, clr_low, clr_onehot;
    logic [ID_W-1:0]   rr_ptr, ptr_nxt, ch_nxt, grant_idx;
    logic              type_nxt, valid_nxt, grant_vld, fire;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_rr_pick (
        .req       (high_pend | low_pend),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign fire       = (state == PRESENT) && out_ready;
    assign clr_onehot = fire ? (NUM_CH'(1) << out_ch) : '0;
    assign clr_high   = (out_type == ALERT_HIGH) ? clr_onehot : '0;
    assign clr_low    = (out_type == ALERT_LOW)  ? clr_onehot : '0;
    assign set_high   = ch_high & enable_mask;
    assign set_low    = ch_low  & enable_mask;

    // A new pulse wins over a same-cycle handshake clear.
    assign high_nxt = (high_pend & ~clr_high) | set_high;
    assign low_nxt  = (low_pend  & ~clr_low)  | set_low;

    always_comb begin
        state_nxt = state;
        ch_nxt    = out_ch;
        type_nxt  = out_type;
        valid_nxt = out_valid;
        ptr_nxt   = rr_ptr;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    ch_nxt    = grant_idx;
                    type_nxt  = high_pend[grant_idx] ? ALERT_HIGH : ALERT_LOW;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                    ptr_nxt   = (out_ch == ID_W'(NUM_CH - 1)) ? '0 : out_ch + ID_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            high_pend   <= '0;
            low_pend    <= '0;
            rr_ptr      <= '0;
            out_ch      <= '0;
            out_type    <= ALERT_LOW;
            out_valid   <= 1'b0;
            pending_any <= 1'b0;
        end else begin
            state       <= state_nxt;
            high_pend   <= high_nxt;
            low_pend    <= low_nxt;
            rr_ptr      <= ptr_nxt;
            out_ch      <= ch_nxt;
            out_type    <= type_nxt;
            out_valid   <= valid_nxt;
            pending_any <= |{high_nxt, low_nxt};
        end
    end

`ifdef ALERT_OVERFLOW_EN
    logic [NUM_CH-1:0] ovf_q, ovf_set;

    // Overflow: accepted pulse lands on a bit that stays pending this cycle.
    assign ovf_set = (set_high & high_pend & ~clr_high) | (set_low & low_pend & ~clr_low);

    always_ff @(posedge clock) begin
        if (!reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_set | (ovf_clr ? '0 : ovf_q);
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = '0;
`endif

endmodule

// File: tb/tb_alert_rr_scheduler.sv
// Randomised scoreboard bench for alert_rr_scheduler against a queue/array model.
module tb_alert_rr_scheduler;

    localparam int N  = 4;
    localparam int ID = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  ch_high, ch_low, enable_mask, ovf;
    logic          out_valid, out_ready, out_type, pending_any, ovf_clr;
    logic [ID-1:0] out_ch;

    int checks = 0;
    int errors = 0;

    logic [ID:0] exp_q[$];

    // Reference model state
    bit       m_ph[N];
    bit       m_pl[N];
    int       m_ptr;
    bit       m_valid;
    int       m_ch;
    bit       m_type;
    bit       m_pany;
    bit [N-1:0] m_ovf;

    alert_rr_scheduler #(.NUM_CH(N), .ID_W(ID)) dut (
        .clock       (clock),
        .reset       (reset),
        .ch_high     (ch_high),
        .ch_low      (ch_low),
        .enable_mask (enable_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_type    (out_type),
        .pending_any (pending_any),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clock = ~clock;

    // Model: one step per rising edge, using the inputs stable across that edge.
    always @(posedge clock) begin
        bit old_h[N];
        bit old_l[N];
        bit fire, sh, sl, ch_clr_h, ch_clr_l;
        old_h = m_ph;
        old_l = m_pl;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_ph[i] = 0;
                m_pl[i] = 0;
            end
            m_ptr = 0; m_valid = 0; m_ch = 0; m_type = 0; m_pany = 0; m_ovf = '0;
            exp_q.delete();
        end else begin
            fire = m_valid && out_ready;
            if (!ovf_clr) begin
                // sticky bits survive unless cleared
            end else begin
                m_ovf = '0;
            end
            for (int i = 0; i < N; i++) begin
                sh = ch_high[i] && enable_mask[i];
                sl = ch_low[i] && enable_mask[i];
                ch_clr_h = fire && m_ch == i && m_type;
                ch_clr_l = fire && m_ch == i && !m_type;
                if ((sh && old_h[i] && !ch_clr_h) || (sl && old_l[i] && !ch_clr_l)) m_ovf[i] = 1'b1;
                m_ph[i] = sh || (old_h[i] && !ch_clr_h);
                m_pl[i] = sl || (old_l[i] && !ch_clr_l);
            end
            if (fire) begin
                m_ptr   = (m_ch + 1) % N;
                m_valid = 0;
            end else if (!m_valid) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!m_valid && (old_h[c] || old_l[c])) begin
                        m_valid = 1;
                        m_ch    = c;
                        m_type  = old_h[c];
                        exp_q.push_back({m_type, ID'(c)});
                    end
                end
            end
            m_pany = 0;
            for (int i = 0; i < N; i++) m_pany = m_pany | m_ph[i] | m_pl[i];
        end
    end

    // Monitor: compare mid-cycle, pop the expected alert when it is accepted.
    always @(negedge clock) begin
        logic [N-1:0] exp_ovf;
`ifdef ALERT_OVERFLOW_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = '0;
`endif
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL valid at %0t: got %b want %b", $time, out_valid, m_valid);
        end
        checks++;
        if (pending_any !== m_pany) begin
            errors++;
            $display("FAIL pending_any at %0t: got %b want %b", $time, pending_any, m_pany);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf at %0t: got %b want %b", $time, ovf, exp_ovf);
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL alert at %0t: got ch %0d type %b want none", $time, out_ch, out_type);
            end else begin
                if ({out_type, out_ch} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL alert at %0t: got ch %0d type %b want ch %0d type %b",
                             $time, out_ch, out_type, exp_q[0][ID-1:0], exp_q[0][ID]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [N-1:0] h, input logic [N-1:0] l, input logic [N-1:0] m,
                         input logic r, input logic oc, input logic rst);
        @(posedge clock);
        #2;
        ch_high = h; ch_low = l; enable_mask = m; out_ready = r; ovf_clr = oc; reset = rst;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive('0, '0, 4'hF, r, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; ch_high = '0; ch_low = '0; enable_mask = 4'hF; out_ready = 1'b1; ovf_clr = 1'b0;
        drive('0, '0, 4'hF, 1'b1, 1'b0, 1'b0);
        drive('0, '0, 4'hF, 1'b1, 1'b0, 1'b0);
        // single high alert on channel 2
        drive(4'b0100, '0, 4'hF, 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        // all four low alerts together
        drive('0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
        idle(10, 1'b1);
        // pointer back to 0, then both bits on ch1 plus high on ch3
        drive('0, '0, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(4'b1010, 4'b0010, 4'hF, 1'b1, 1'b0, 1'b1);
        idle(8, 1'b1);
        // sink stalled while more alerts arrive
        drive(4'b0001, '0, 4'hF, 1'b0, 1'b0, 1'b1);
        drive('0, 4'b0100, 4'hF, 1'b0, 1'b0, 1'b1);
        drive(4'b1000, '0, 4'hF, 1'b0, 1'b0, 1'b1);
        idle(8, 1'b0);
        idle(10, 1'b1);
        // masked channel 0
        drive(4'b0001, '0, 4'b1110, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        // overflow on channel 2 with sink stalled, then clear
        drive(4'b0001, '0, 4'hF, 1'b0, 1'b0, 1'b1);
        drive(4'b0100, '0, 4'hF, 1'b0, 1'b0, 1'b1);
        drive(4'b0100, '0, 4'hF, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        drive('0, '0, 4'hF, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0);
        // reset while an alert is presented
        drive('0, '0, 4'hF, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);
        // randomised traffic
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] h, l, m;
            for (int b = 0; b < N; b++) begin
                h[b] = ($urandom_range(0, 5) == 0);
                l[b] = ($urandom_range(0, 5) == 0);
            end
            m = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : 4'hF;
            drive(h, l, m, ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 99) != 0));
        end
        idle(30, 1'b1);
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d alerts outstanding want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
